// File: rtl/etm_error_monitor_pkg.sv
// Shared definitions for the ETM error monitor: default widths and FSM states.
package etm_error_monitor_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } etm_state_e;

  function automatic int prod_w(input int width);
    return 2 * width;
  endfunction

  localparam int PROD_W_DEF = prod_w(WIDTH_DEF);

endpackage

// File: rtl/etm_err_dist.sv
// Three-stage error-distance pipeline: register operands, exact product, |exact - approx|.
module etm_err_dist
  import etm_error_monitor_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int PROD_W = PROD_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_v,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [PROD_W-1:0] c_approx,
  output logic              out_v,
  output logic [PROD_W-1:0] ed,
  output logic              busy
);

  logic              vld_p0, vld_p1, vld_p2;
  logic [WIDTH-1:0]  a_p0, b_p0;
  logic [PROD_W-1:0] c_p0, c_p1, exact_p1, ed_p2;
  logic signed [PROD_W:0] diff_p1;

  // Magnitude of the signed difference always fits in PROD_W bits.
  function automatic logic [PROD_W-1:0] abs_diff(input logic signed [PROD_W:0] d);
    logic signed [PROD_W:0] m;
    m = d[PROD_W] ? -d : d;
    return m[PROD_W-1:0];
  endfunction

  always_comb diff_p1 = $signed({1'b0, exact_p1}) - $signed({1'b0, c_p1});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (flush) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p0 <= in_v;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    // S1: capture operands and approximate product
    if (in_v) begin
      a_p0 <= a;
      b_p0 <= b;
      c_p0 <= c_approx;
    end
    // S2: exact unsigned product
    if (vld_p0) begin
      exact_p1 <= PROD_W'(a_p0) * PROD_W'(b_p0);
      c_p1     <= c_p0;
    end
    // S3: absolute error distance
    if (vld_p1) ed_p2 <= abs_diff(diff_p1);
  end

  assign out_v = vld_p2;
  assign ed    = ed_p2;
  assign busy  = vld_p0 | vld_p1 | vld_p2;

endmodule

// File: rtl/etm_error_monitor.sv
// Windowed on-chip error statistics for the approximate ETM multiplier output.
module etm_error_monitor
  import etm_error_monitor_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int WINDOW = 1000,
  parameter int SUM_W  = 48,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2*WIDTH-1:0]   c_approx,
  output logic                 stat_valid,
  output logic                 win_done,
  output logic [SUM_W-1:0]     stat_sum_ed,
  output logic [2*WIDTH-1:0]   stat_max_ed,
  output logic [CNT_W-1:0]     stat_mismatch,
  output logic [CNT_W-1:0]     stat_samples
);

  localparam int PROD_W = prod_w(WIDTH);
  localparam int ACC_W  = $clog2(WINDOW + 1);

  etm_state_e        state;
  logic [ACC_W-1:0]  acc_cnt;
  logic              accept, ed_v, pipe_busy, stats_zero;
  logic [PROD_W-1:0] ed;

  // Assumes SUM_W >= PROD_W so an ED always fits the accumulator.
  function automatic logic [SUM_W-1:0] sat_add_sum(input logic [SUM_W-1:0] acc,
                                                    input logic [PROD_W-1:0] inc);
    logic [SUM_W:0] s;
    s = {1'b0, acc} + {{(SUM_W + 1 - PROD_W){1'b0}}, inc};
    return s[SUM_W] ? {SUM_W{1'b1}} : s[SUM_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic en);
    return (en && cnt != {CNT_W{1'b1}}) ? cnt + 1'b1 : cnt;
  endfunction

  assign accept     = in_valid & in_ready;
  assign stats_zero = clear | (start & (state == IDLE || state == DONE));

  etm_err_dist #(.WIDTH(WIDTH), .PROD_W(PROD_W)) u_err_dist (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (clear),
    .in_v     (accept),
    .a        (a),
    .b        (b),
    .c_approx (c_approx),
    .out_v    (ed_v),
    .ed       (ed),
    .busy     (pipe_busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc_cnt    <= '0;
      in_ready   <= 1'b0;
      stat_valid <= 1'b0;
      win_done   <= 1'b0;
    end else begin
      win_done <= 1'b0;
      if (clear) begin
        state      <= IDLE;
        acc_cnt    <= '0;
        in_ready   <= 1'b0;
        stat_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            acc_cnt  <= '0;
            in_ready <= 1'b1;
            state    <= RUN;
          end
          RUN: if (accept) begin
            acc_cnt <= acc_cnt + 1'b1;
            if (acc_cnt == ACC_W'(WINDOW - 1)) begin
              in_ready <= 1'b0;
              state    <= DRAIN;
            end
          end
          DRAIN: if (!pipe_busy) begin
            stat_valid <= 1'b1;
            win_done   <= 1'b1;
            state      <= DONE;
          end
          DONE: if (start) begin
            acc_cnt    <= '0;
            stat_valid <= 1'b0;
            in_ready   <= 1'b1;
            state      <= RUN;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Accumulate stage: zeroing (clear or a window start) overrides any ED in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_sum_ed   <= '0;
      stat_max_ed   <= '0;
      stat_mismatch <= '0;
      stat_samples  <= '0;
    end else if (stats_zero) begin
      stat_sum_ed   <= '0;
      stat_max_ed   <= '0;
      stat_mismatch <= '0;
      stat_samples  <= '0;
    end else if (ed_v) begin
      stat_sum_ed   <= sat_add_sum(stat_sum_ed, ed);
      if (ed > stat_max_ed) stat_max_ed <= ed;
      stat_mismatch <= sat_inc(stat_mismatch, ed != '0);
      stat_samples  <= sat_inc(stat_samples, 1'b1);
    end
  end

endmodule

// File: tb/tb_etm_error_monitor.sv
// Bench for etm_error_monitor: two instances (WINDOW=4/SUM_W=33 and WINDOW=1/SUM_W=48).
module tb_etm_error_monitor;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] c;
  } sample_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0, clear0 = 1'b0, iv0 = 1'b0;
  logic        start1 = 1'b0, clear1 = 1'b0, iv1 = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic [31:0] c = '0;

  logic        rdy0, sv0, wd0, rdy1, sv1, wd1;
  logic [32:0] sum0;
  logic [47:0] sum1;
  logic [31:0] mx0, mx1;
  logic [15:0] mm0, mm1, smp0, smp1;

  int          sel = 0;
  logic        rdy, sv, wd;
  logic [63:0] sum, mx, mm, smp;

  int tests = 0;
  int fails = 0;
  sample_t    dir_q[$];
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  etm_error_monitor #(.WIDTH(16), .WINDOW(4), .SUM_W(33), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .clear(clear0), .in_valid(iv0),
    .in_ready(rdy0), .a(a), .b(b), .c_approx(c), .stat_valid(sv0), .win_done(wd0),
    .stat_sum_ed(sum0), .stat_max_ed(mx0), .stat_mismatch(mm0), .stat_samples(smp0));

  etm_error_monitor #(.WIDTH(16), .WINDOW(1), .SUM_W(48), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .clear(clear1), .in_valid(iv1),
    .in_ready(rdy1), .a(a), .b(b), .c_approx(c), .stat_valid(sv1), .win_done(wd1),
    .stat_sum_ed(sum1), .stat_max_ed(mx1), .stat_mismatch(mm1), .stat_samples(smp1));

  always_comb begin
    rdy = rdy0; sv = sv0; wd = wd0;
    sum = 64'(sum0); mx = 64'(mx0); mm = 64'(mm0); smp = 64'(smp0);
    if (sel != 0) begin
      rdy = rdy1; sv = sv1; wd = wd1;
      sum = 64'(sum1); mx = 64'(mx1); mm = 64'(mm1); smp = 64'(smp1);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_start(input logic v);
    if (sel == 0) start0 = v; else start1 = v;
  endtask
  task automatic set_clear(input logic v);
    if (sel == 0) clear0 = v; else clear1 = v;
  endtask
  task automatic set_iv(input logic v);
    if (sel == 0) iv0 = v; else iv1 = v;
  endtask

  function automatic int win_sz();
    return (sel == 0) ? 4 : 1;
  endfunction

  function automatic logic [63:0] sum_lim();
    return (sel == 0) ? ((64'd1 << 33) - 1) : ((64'd1 << 48) - 1);
  endfunction

  function automatic logic [63:0] ref_ed(input sample_t s);
    logic [63:0] ex, cv;
    ex = 64'(s.a) * 64'(s.b);
    cv = 64'(s.c);
    return (ex >= cv) ? ex - cv : cv - ex;
  endfunction

  function automatic sample_t rand_sample();
    sample_t s;
    logic [63:0] ex;
    logic [31:0] off;
    s.a = 16'($urandom);
    s.b = 16'($urandom);
    ex  = 64'(s.a) * 64'(s.b);
    off = 32'($urandom_range(1, 5000));
    case ($urandom_range(0, 3))
      0:       s.c = ex[31:0];
      1:       s.c = ex[31:0] + off;
      2:       s.c = ex[31:0] - off;
      default: s.c = 32'($urandom);
    endcase
    return s;
  endfunction

  task automatic drive(input sample_t s);
    a = s.a; b = s.b; c = s.c;
  endtask

  // Compare the visible statistics against the accepted-sample list.
  task automatic check_stats(input string tag);
    logic [63:0] esum, emax, emm;
    esum = 0; emax = 0; emm = 0;
    foreach (exp_q[i]) begin
      esum = esum + exp_q[i];
      if (esum > sum_lim()) esum = sum_lim();
      if (exp_q[i] > emax) emax = exp_q[i];
      if (exp_q[i] != 0) emm++;
    end
    check({tag, "_sum"}, sum, esum);
    check({tag, "_max"}, mx, emax);
    check({tag, "_mismatch"}, mm, emm);
    check({tag, "_samples"}, smp, 64'(exp_q.size()));
  endtask

  // One window: start, feed samples (directed queue first, else random with gaps), drain, check.
  task automatic run_window(input string tag, input int gap_pct, input logic hold_drain);
    int cnt, cyc, n;
    logic v;
    sample_t s;
    exp_q.delete();
    set_start(1'b1);
    step();
    set_start(1'b0);
    cnt = 0; cyc = 0;
    while (cnt < win_sz() && cyc < 200) begin
      check({tag, "_in_ready_run"}, rdy, 1);
      v = (dir_q.size() != 0) || ($urandom_range(0, 99) >= gap_pct);
      s = (v && dir_q.size() != 0) ? dir_q.pop_front() : rand_sample();
      drive(s);
      set_iv(v);
      if (v) begin
        exp_q.push_back(ref_ed(s));
        cnt++;
      end
      step();
      cyc++;
    end
    check({tag, "_accepts"}, 64'(cnt), 64'(win_sz()));
    set_iv(hold_drain);
    n = 0;
    while (sv !== 1'b1 && n < 20) begin
      check({tag, "_in_ready_drain"}, rdy, 0);
      drive(rand_sample());
      step();
      n++;
    end
    check({tag, "_done_reached"}, sv, 1);
    check({tag, "_win_done_first"}, wd, 1);
    check({tag, "_in_ready_done"}, rdy, 0);
    check_stats(tag);
    drive(rand_sample());
    step();
    check({tag, "_win_done_pulse"}, wd, 0);
    check({tag, "_stat_valid_hold"}, sv, 1);
    check_stats({tag, "_hold"});
    set_iv(1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"}, rdy, 0);
    check({tag, "_stat_valid"}, sv, 0);
    check({tag, "_win_done"}, wd, 0);
    check({tag, "_sum"}, sum, 0);
    check({tag, "_max"}, mx, 0);
    check({tag, "_mismatch"}, mm, 0);
    check({tag, "_samples"}, smp, 0);
  endtask

  initial begin
    // Reset state
    #12;
    sel = 0; check_all_zero("rst0");
    sel = 1; check_all_zero("rst1");
    rst_n = 1'b1;
    step();
    step();
    sel = 0; check_all_zero("idle0");

    // Directed window with known errors
    dir_q.push_back('{16'd3, 16'd5, 32'd15});
    dir_q.push_back('{16'd100, 16'd200, 32'd19968});
    dir_q.push_back('{16'd65535, 16'd65535, 32'd4294836225});
    dir_q.push_back('{16'd7, 16'd9, 32'd70});
    run_window("t2", 0, 1'b0);
    check("t2_sum_const", sum, 39);
    check("t2_max_const", mx, 32);
    check("t2_mm_const", mm, 2);

    // Asynchronous reset while in DONE and mid-RUN
    #3 rst_n = 1'b0;
    #1 check_all_zero("rst_done");
    #3 rst_n = 1'b1;
    step();
    set_start(1'b1); step(); set_start(1'b0);
    set_iv(1'b1);
    drive(rand_sample()); step();
    drive(rand_sample()); step();
    check("run_in_ready", rdy, 1);
    #3 rst_n = 1'b0;
    #1 check_all_zero("rst_run");
    set_iv(1'b0);
    #2 rst_n = 1'b1;
    step(); step();
    check_all_zero("after_rst");

    // WINDOW=1: overestimate, then underestimate in a second window
    sel = 1;
    dir_q.push_back('{16'd10, 16'd10, 32'd110});
    run_window("t3o", 0, 1'b1);
    check("t3o_sum_const", sum, 10);
    dir_q.push_back('{16'd10, 16'd10, 32'd90});
    run_window("t3u", 0, 1'b1);
    check("t3u_sum_const", sum, 10);

    // Randomized windows with gaps and in_valid held during drain/done
    for (int w = 0; w < 8; w++) begin
      sel = w % 2;
      run_window($sformatf("rnd%0d", w), 50, 1'b1);
    end

    // clear together with start in DONE
    sel = 0;
    set_start(1'b1); set_clear(1'b1);
    step();
    set_start(1'b0); set_clear(1'b0);
    check_all_zero("clr_start");
    step();
    check("clr_start_idle", rdy, 0);

    // clear in DRAIN with samples in flight
    set_start(1'b1); step(); set_start(1'b0);
    set_iv(1'b1);
    for (int i = 0; i < 4; i++) begin
      drive('{16'd0, 16'd1, 32'd1000});
      step();
    end
    set_iv(1'b0);
    set_clear(1'b1);
    step();
    set_clear(1'b0);
    for (int i = 0; i < 5; i++) begin
      check_all_zero($sformatf("clr_drain%0d", i));
      step();
    end

    // Sum saturation at SUM_W=33 with maximal ED
    for (int i = 0; i < 4; i++) dir_q.push_back('{16'd0, 16'd5, 32'hFFFF_FFFF});
    run_window("sat", 0, 1'b0);
    check("sat_sum_const", sum, (64'd1 << 33) - 1);
    check("sat_max_const", mx, 64'hFFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
